mergesort_main: RTL and testbench

HLS-style top block (`main`) that sorts a fixed 16-element array of signed 16-bit integers, held in internal byte-addressed RAM, in ascending order using bottom-up mergesort. It is started by a one-cycle `start_port` pulse and reports completion with a one-cycle `done_port` pulse. A two-channel byte slave port gives external access to the RAM while the block is idle. It is the top of the sorting kernel, driven directly by a simple start/done controller.

---
 rtl/mergesort_main.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_mergesort_main.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mergesort_main.sv
// mergesort_main: bottom-up mergesort of 16 signed 16-bit elements held in a
// 128-byte register RAM, with a two-channel byte slave port that is live only
// while the sorter is idle.
// Optional feature macro: MAIN_SORTED_CHECK_EN adds a final CHECK scan that
// writes 1 (sorted) or 0 (unsorted) to byte address 0 before done.
module mergesort_main #(
  parameter int MEM_var_28859_28863 = 64,
  parameter int MEM_var_28861_28867 = 32,
  parameter int MEM_var_29010_28863 = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy
);

  localparam logic [6:0] ARR_BASE = 7'(MEM_var_28859_28863);
  localparam logic [6:0] SCR_BASE = 7'(MEM_var_28861_28867);
  localparam logic [6:0] SCW_BASE = 7'(MEM_var_29010_28863);

  // The merge write stage and the copy-back stage must agree on the scratch buffer.
  if (MEM_var_29010_28863 != MEM_var_28861_28867) begin : g_scratch_mismatch
    $error("mergesort_main: MEM_var_29010_28863 must equal MEM_var_28861_28867");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MERGE_RD  = 3'd1,
    S_MERGE_CMP = 3'd2,
    S_COPY      = 3'd3,
`ifdef MAIN_SORTED_CHECK_EN
    S_CHECK     = 3'd4,
`endif
    S_DONE      = 3'd5
  } state_t;

  function automatic logic [15:0] init_elem(input logic [3:0] idx);
    case (idx)
      4'd0:  init_elem = 16'h003F;  // 63
      4'd1:  init_elem = 16'h0005;  // 5
      4'd2:  init_elem = 16'h002A;  // 42
      4'd3:  init_elem = 16'hFFF9;  // -7
      4'd4:  init_elem = 16'h0000;  // 0
      4'd5:  init_elem = 16'h0012;  // 18
      4'd6:  init_elem = 16'h0012;  // 18
      4'd7:  init_elem = 16'hFF9C;  // -100
      4'd8:  init_elem = 16'h0007;  // 7
      4'd9:  init_elem = 16'h03E8;  // 1000
      4'd10: init_elem = 16'hFFFF;  // -1
      4'd11: init_elem = 16'h0003;  // 3
      4'd12: init_elem = 16'h0063;  // 99
      4'd13: init_elem = 16'h000C;  // 12
      4'd14: init_elem = 16'hFFCE;  // -50
      4'd15: init_elem = 16'h001B;  // 27
      default: init_elem = 16'h0000;
    endcase
  endfunction

  function automatic logic [1023:0] mem_reset_image();
    logic [1023:0] img;
    logic [15:0]   val;
    logic [6:0]    addr;
    img = '0;
    for (int i = 0; i < 16; i++) begin
      val  = init_elem(4'(i));
      addr = ARR_BASE + 7'(2 * i);
      img[{addr, 3'b000} +: 8]         = val[7:0];
      img[{addr + 7'd1, 3'b000} +: 8]  = val[15:8];
    end
    return img;
  endfunction

  // Byte address of element idx (0..16) of a halfword array at base.
  function automatic logic [6:0] elem_addr(input logic [6:0] base, input logic [4:0] idx);
    return base + {1'b0, idx, 1'b0};
  endfunction

  // Little-endian halfword read; the high-byte address wraps inside the RAM.
  function automatic logic [15:0] rd_half(input logic [1023:0] m, input logic [6:0] a);
    return {m[{a + 7'd1, 3'b000} +: 8], m[{a, 3'b000} +: 8]};
  endfunction

  state_t        state_q, state_d;
  logic          rd_ph_q, rd_ph_d;
  logic          done_ph_q, done_ph_d;
  logic [1:0]    pass_q, pass_d;
  logic [4:0]    l_q, l_d, le_q, le_d, r_q, r_d, re_q, re_d, k_q, k_d, cb_q, cb_d;
  logic [15:0]   a_q, a_d, b_q, b_d;
  logic          done_q, done_d;
  logic [1:0]    rdy_q, rdy_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [1023:0] mem_q, mem_d;
`ifdef MAIN_SORTED_CHECK_EN
  logic [4:0]    ck_q, ck_d;
  logic          ok_q, ok_d;
`endif

  logic [4:0]  w_s;
  logic        take_left_s;
  logic [15:0] wr_word_s;
  logic [7:0]  copy_byte_s;
  logic        unused_size_s;

  // Access size is always treated as one byte.
  assign unused_size_s = ^S_data_ram_size;
  assign w_s           = 5'd1 << pass_q;
  assign take_left_s   = (l_q < le_q) && (!(r_q < re_q) || ($signed(a_q) <= $signed(b_q)));
  assign wr_word_s     = take_left_s ? a_q : b_q;
  assign copy_byte_s   = mem_q[{SCR_BASE + {2'b00, cb_q}, 3'b000} +: 8];

  // Next-state, datapath and RAM-update logic for the sorter and slave port.
  always_comb begin
    state_d   = state_q;
    rd_ph_d   = rd_ph_q;
    done_ph_d = done_ph_q;
    pass_d    = pass_q;
    l_d = l_q; le_d = le_q; r_d = r_q; re_d = re_q; k_d = k_q; cb_d = cb_q;
    a_d       = a_q;
    b_d       = b_q;
    done_d    = 1'b0;
    rdy_d     = 2'b00;
    rdata_d   = rdata_q;
    mem_d     = mem_q;
`ifdef MAIN_SORTED_CHECK_EN
    ck_d      = ck_q;
    ok_d      = ok_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Channel 1 is applied last so it wins a same-address write; reads see old data.
        for (int ch = 0; ch < 2; ch++) begin
          if (S_we_ram[ch]) begin
            mem_d[{S_addr_ram[7*ch +: 7], 3'b000} +: 8] = S_Wdata_ram[8*ch +: 8];
          end else begin
            mem_d = mem_d;
          end
          if (S_oe_ram[ch]) begin
            rdata_d[8*ch +: 8] = mem_q[{S_addr_ram[7*ch +: 7], 3'b000} +: 8];
          end else begin
            rdata_d[8*ch +: 8] = rdata_q[8*ch +: 8];
          end
          rdy_d[ch] = S_oe_ram[ch] | S_we_ram[ch];
        end
        if (start_port) begin
          state_d = S_MERGE_RD;
          rd_ph_d = 1'b0;
          pass_d  = 2'd0;
          l_d = 5'd0; le_d = 5'd1; r_d = 5'd1; re_d = 5'd2; k_d = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MERGE_RD: begin
        // Two cycles: left head, then right head.
        if (!rd_ph_q) begin
          a_d     = rd_half(mem_q, elem_addr(ARR_BASE, l_q));
          rd_ph_d = 1'b1;
        end else begin
          b_d     = rd_half(mem_q, elem_addr(ARR_BASE, r_q));
          rd_ph_d = 1'b0;
          state_d = S_MERGE_CMP;
        end
      end
      S_MERGE_CMP: begin
        mem_d[{elem_addr(SCW_BASE, k_q), 3'b000} +: 16] = wr_word_s;
        if (take_left_s) begin
          l_d = l_q + 5'd1;
        end else begin
          r_d = r_q + 5'd1;
        end
        k_d = k_q + 5'd1;
        if (k_q + 5'd1 == re_q) begin
          l_d  = re_q;
          le_d = re_q + w_s;
          r_d  = re_q + w_s;
          re_d = re_q + (w_s << 1);
        end else begin
          re_d = re_q;
        end
        if (k_q == 5'd15) begin
          state_d = S_COPY;
          cb_d    = 5'd0;
        end else begin
          state_d = S_MERGE_RD;
        end
      end
      S_COPY: begin
        mem_d[{ARR_BASE + {2'b00, cb_q}, 3'b000} +: 8] = copy_byte_s;
        cb_d = cb_q + 5'd1;
        if (cb_q == 5'd31) begin
          if (pass_q == 2'd3) begin
`ifdef MAIN_SORTED_CHECK_EN
            state_d = S_CHECK;
            ck_d    = 5'd0;
`else
            state_d   = S_DONE;
            done_ph_d = 1'b0;
`endif
          end else begin
            pass_d  = pass_q + 2'd1;
            l_d  = 5'd0;
            le_d = w_s << 1;
            r_d  = w_s << 1;
            re_d = w_s << 2;
            k_d  = 5'd0;
            rd_ph_d = 1'b0;
            state_d = S_MERGE_RD;
          end
        end else begin
          state_d = S_COPY;
        end
      end
`ifdef MAIN_SORTED_CHECK_EN
      S_CHECK: begin
        // Step 0 arms the flag, steps 1..15 test pair (k-1,k), step 16 stores it.
        ck_d = ck_q + 5'd1;
        if (ck_q == 5'd0) begin
          ok_d = 1'b1;
        end else if (ck_q < 5'd16) begin
          if ($signed(rd_half(mem_q, elem_addr(ARR_BASE, ck_q - 5'd1))) >
              $signed(rd_half(mem_q, elem_addr(ARR_BASE, ck_q)))) begin
            ok_d = 1'b0;
          end else begin
            ok_d = ok_q;
          end
        end else begin
          mem_d[7:0] = {7'b0000000, ok_q};
          state_d    = S_DONE;
          done_ph_d  = 1'b0;
        end
      end
`endif
      S_DONE: begin
        if (!done_ph_q) begin
          done_ph_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and RAM registers; reset reloads the initial array image.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_ph_q   <= 1'b0;
      done_ph_q <= 1'b0;
      pass_q    <= 2'd0;
      l_q <= 5'd0; le_q <= 5'd0; r_q <= 5'd0; re_q <= 5'd0; k_q <= 5'd0; cb_q <= 5'd0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      done_q    <= 1'b0;
      rdy_q     <= 2'b00;
      rdata_q   <= 16'h0000;
      mem_q     <= mem_reset_image();
`ifdef MAIN_SORTED_CHECK_EN
      ck_q      <= 5'd0;
      ok_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_ph_q   <= rd_ph_d;
      done_ph_q <= done_ph_d;
      pass_q    <= pass_d;
      l_q <= l_d; le_q <= le_d; r_q <= r_d; re_q <= re_d; k_q <= k_d; cb_q <= cb_d;
      a_q       <= a_d;
      b_q       <= b_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
      rdata_q   <= rdata_d;
      mem_q     <= mem_d;
`ifdef MAIN_SORTED_CHECK_EN
      ck_q      <= ck_d;
      ok_q      <= ok_d;
`endif
    end
  end

  assign done_port      = done_q;
  assign Sout_DataRdy   = rdy_q;
  assign Sout_Rdata_ram = rdata_q;

endmodule

// File: tb/tb_mergesort_main.sv
// Directed testbench for mergesort_main: reset state, sort latency and result,
// slave port collisions, busy behaviour, reset abort and (with
// MAIN_SORTED_CHECK_EN) the sorted-check flag.
module tb_mergesort_main;

`ifdef MAIN_SORTED_CHECK_EN
  localparam int LAT    = 339;
  localparam int EXP_B0 = 1;
`else
  localparam int LAT    = 322;
  localparam int EXP_B0 = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start_port;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;

  int checks = 0;
  int errors = 0;

  logic [15:0] init_vals [16] = '{16'h003F, 16'h0005, 16'h002A, 16'hFFF9, 16'h0000, 16'h0012,
                                  16'h0012, 16'hFF9C, 16'h0007, 16'h03E8, 16'hFFFF, 16'h0003,
                                  16'h0063, 16'h000C, 16'hFFCE, 16'h001B};
  logic [15:0] sorted_vals [16] = '{16'hFF9C, 16'hFFCE, 16'hFFF9, 16'hFFFF, 16'h0000, 16'h0003,
                                    16'h0005, 16'h0007, 16'h000C, 16'h0012, 16'h0012, 16'h001B,
                                    16'h002A, 16'h003F, 16'h0063, 16'h03E8};

  mergesort_main dut (
    .clock           (clock),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Read element idx: ch0 fetches the low byte, ch1 the high byte.
  task automatic rd_elem(input int idx, output logic [15:0] v, output logic [1:0] rdy);
    @(negedge clock);
    S_oe_ram   = 2'b11;
    S_addr_ram = {7'(65 + 2 * idx), 7'(64 + 2 * idx)};
    @(negedge clock);
    v   = Sout_Rdata_ram;
    rdy = Sout_DataRdy;
    S_oe_ram = 2'b00;
  endtask

  task automatic rd_byte(input logic [6:0] a, output logic [7:0] v);
    @(negedge clock);
    S_oe_ram   = 2'b01;
    S_addr_ram = {7'd0, a};
    @(negedge clock);
    v = Sout_Rdata_ram[7:0];
    S_oe_ram = 2'b00;
  endtask

  task automatic wr_elem(input int idx, input logic [15:0] val);
    @(negedge clock);
    S_we_ram    = 2'b11;
    S_addr_ram  = {7'(65 + 2 * idx), 7'(64 + 2 * idx)};
    S_Wdata_ram = val;
    @(negedge clock);
    S_we_ram = 2'b00;
  endtask

  // Pulse start and record the first done cycle and the number of done cycles.
  task automatic run_sort(output int lat, output int ndone);
    @(negedge clock);
    start_port = 1'b1;
    @(posedge clock);
    #1 start_port = 1'b0;
    lat = -1;
    ndone = 0;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(posedge clock);
      #1;
      if (done_port) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic [1:0]  rdy;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (done_port !== 1'b0 || Sout_DataRdy !== 2'b00 || Sout_Rdata_ram !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b rdy=%b rdata=%h, expected 0/00/0000",
               done_port, Sout_DataRdy, Sout_Rdata_ram);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_elem(i, v, rdy);
      checks++;
      if (v !== init_vals[i] || rdy !== 2'b11) begin
        errors++;
        $display("FAIL reset_elem[%0d]: got %h rdy=%b, expected %h rdy=11", i, v, rdy, init_vals[i]);
      end
    end
  endtask

  task automatic test_sort_init();
    int lat, nd;
    logic [15:0] v;
    logic [1:0]  rdy;
    logic [7:0]  b0;
    run_sort(lat, nd);
    checks++;
    if (lat != LAT || nd != 1) begin
      errors++;
      $display("FAIL sort_init_latency: got lat=%0d pulses=%0d, expected lat=%0d pulses=1", lat, nd, LAT);
    end
    for (int i = 0; i < 16; i++) begin
      rd_elem(i, v, rdy);
      checks++;
      if (v !== sorted_vals[i]) begin
        errors++;
        $display("FAIL sort_init_elem[%0d]: got %h, expected %h", i, v, sorted_vals[i]);
      end
    end
    rd_byte(7'd0, b0);
    checks++;
    if (b0 !== 8'(EXP_B0)) begin
      errors++;
      $display("FAIL sort_init_byte0: got %0d, expected %0d", b0, EXP_B0);
    end
  endtask

  task automatic test_desc();
    int lat, nd;
    logic [15:0] v;
    logic [1:0]  rdy;
    for (int i = 0; i < 16; i++) wr_elem(i, 16'(15 - i));
    run_sort(lat, nd);
    checks++;
    if (lat != LAT || nd != 1) begin
      errors++;
      $display("FAIL desc_latency: got lat=%0d pulses=%0d, expected lat=%0d pulses=1", lat, nd, LAT);
    end
    for (int i = 0; i < 16; i++) begin
      rd_elem(i, v, rdy);
      checks++;
      if (v !== 16'(i)) begin
        errors++;
        $display("FAIL desc_elem[%0d]: got %h, expected %h", i, v, 16'(i));
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] b;
    @(negedge clock);
    S_we_ram    = 2'b11;
    S_addr_ram  = {7'd64, 7'd64};
    S_Wdata_ram = {8'h55, 8'hAA};
    @(negedge clock);
    S_we_ram = 2'b00;
    checks++;
    if (Sout_DataRdy !== 2'b11) begin
      errors++;
      $display("FAIL collision_rdy: got %b, expected 11", Sout_DataRdy);
    end
    @(negedge clock);
    checks++;
    if (Sout_DataRdy !== 2'b00) begin
      errors++;
      $display("FAIL collision_rdy_drop: got %b, expected 00", Sout_DataRdy);
    end
    rd_byte(7'd64, b);
    checks++;
    if (b !== 8'h55) begin
      errors++;
      $display("FAIL collision_data: got %h, expected 55", b);
    end
    // oe and we together on ch0: old byte returned, new byte stored.
    @(negedge clock);
    S_oe_ram    = 2'b01;
    S_we_ram    = 2'b01;
    S_addr_ram  = {7'd0, 7'd65};
    S_Wdata_ram = 16'h0012;
    @(negedge clock);
    S_oe_ram = 2'b00;
    S_we_ram = 2'b00;
    checks++;
    if (Sout_Rdata_ram[7:0] !== 8'h00 || Sout_DataRdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rw_same_old: got %h rdy=%b, expected 00 rdy=1", Sout_Rdata_ram[7:0], Sout_DataRdy[0]);
    end
    rd_byte(7'd65, b);
    checks++;
    if (b !== 8'h12) begin
      errors++;
      $display("FAIL rw_same_new: got %h, expected 12", b);
    end
  endtask

  task automatic test_busy();
    int nd, lat, bad_rdy;
    logic [15:0] v;
    logic [1:0]  rdy;
    nd = 0; lat = -1; bad_rdy = 0;
    @(negedge clock);
    start_port = 1'b1;
    @(posedge clock);
    #1 start_port = 1'b0;
    for (int c = 1; c <= LAT + 30; c++) begin
      @(posedge clock);
      #1;
      if (c >= 11 && c <= 16 && Sout_DataRdy !== 2'b00) bad_rdy++;
      if (done_port) begin
        nd++;
        if (lat < 0) lat = c;
      end
      S_oe_ram   = (c >= 10 && c < 15) ? 2'b11 : 2'b00;
      S_addr_ram = {7'd65, 7'd64};
      start_port = (c == 50);
    end
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL busy_rdy: got %0d acknowledged cycles, expected 0", bad_rdy);
    end
    checks++;
    if (nd != 1 || lat != LAT) begin
      errors++;
      $display("FAIL busy_start: got pulses=%0d lat=%0d, expected pulses=1 lat=%0d", nd, lat, LAT);
    end
    // Array held 0x1255,1..15: sorted gives 1..15 then 0x1255.
    rd_elem(0, v, rdy);
    checks++;
    if (v !== 16'h0001) begin
      errors++;
      $display("FAIL busy_elem0: got %h, expected 0001", v);
    end
    rd_elem(15, v, rdy);
    checks++;
    if (v !== 16'h1255) begin
      errors++;
      $display("FAIL busy_elem15: got %h, expected 1255", v);
    end
  endtask

  task automatic test_abort();
    int nd;
    logic [15:0] v;
    logic [1:0]  rdy;
    nd = 0;
    @(negedge clock);
    start_port = 1'b1;
    @(posedge clock);
    #1 start_port = 1'b0;
    repeat (100) @(posedge clock);
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < LAT + 50; c++) begin
      @(posedge clock);
      #1;
      if (done_port) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_done: got %0d pulses, expected 0", nd);
    end
    for (int i = 0; i < 16; i++) begin
      rd_elem(i, v, rdy);
      checks++;
      if (v !== init_vals[i]) begin
        errors++;
        $display("FAIL abort_elem[%0d]: got %h, expected %h", i, v, init_vals[i]);
      end
    end
  endtask

`ifdef MAIN_SORTED_CHECK_EN
  task automatic test_check_unsorted();
    int nd, found;
    logic [7:0] b0;
    nd = 0; found = 0;
    do_reset();
    @(negedge clock);
    start_port = 1'b1;
    @(posedge clock);
    #1 start_port = 1'b0;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(posedge clock);
      #1;
      if (done_port) nd++;
      if (found == 0 && dut.state_q == 3'd3 && dut.pass_q == 2'd3 && dut.cb_q == 5'd1) begin
        // Corrupt the high byte of element 0 on its last copy-back.
        found = 1;
        force dut.copy_byte_s = 8'h7F;
        @(posedge clock);
        #1 release dut.copy_byte_s;
        c++;
        if (done_port) nd++;
      end
    end
    checks++;
    if (found != 1 || nd != 1) begin
      errors++;
      $display("FAIL check_force: got found=%0d pulses=%0d, expected 1/1", found, nd);
    end
    rd_byte(7'd0, b0);
    checks++;
    if (b0 !== 8'h00) begin
      errors++;
      $display("FAIL check_unsorted_byte0: got %0d, expected 0", b0);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start_port = 1'b0;
    S_oe_ram = 2'b00;
    S_we_ram = 2'b00;
    S_addr_ram = 14'd0;
    S_Wdata_ram = 16'h0000;
    S_data_ram_size = 8'h88;
    test_reset();
    test_sort_init();
    test_desc();
    test_collision();
    test_busy();
    test_abort();
`ifdef MAIN_SORTED_CHECK_EN
    test_check_unsorted();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
